led_colour_sequencer: RTL

//  Parametrised, multi-channel successor of the single 3-bit LED colour cycler.

---
 rtl/led_seq_pkg.sv | 36 +++
 rtl/led_seq_channel.sv | 60 ++++++
 rtl/led_colour_sequencer.sv | 67 ++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the multi-channel LED colour sequencer: direction codes,
// channel state type and the wrap-around stepping rules.
package led_seq_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // One step inside [min_v, max_v]; leaving either end re-enters at the opposite end.
  function automatic int next_colour(input int cur, input logic dir,
                                     input int min_v, input int max_v);
    int nxt;
    if (dir == DIR_UP) begin
      nxt = (cur >= max_v) ? min_v : cur + 1;
    end else begin
      nxt = (cur <= min_v) ? max_v : cur - 1;
    end
    return nxt;
  endfunction

  function automatic logic is_wrap(input int cur, input logic dir,
                                   input int min_v, input int max_v);
    logic w;
    if (dir == DIR_UP) begin
      w = (cur >= max_v);
    end else begin
      w = (cur <= min_v);
    end
    return w;
  endfunction

endpackage

// File: rtl/led_seq_channel.sv
// One colour channel: button edge detect, IDLE/RUN state, colour register and
// a single-cycle wrap pulse. Current state is exported for observation.
module led_seq_channel
  import led_seq_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MIN_VAL  = 1,
  parameter int MAX_VAL  = 6,
  parameter int BTN_EDGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             tick,
  input  logic             auto_en,
  input  logic             dir,
  input  logic             hold,
  output logic [WIDTH-1:0] colour,
  output logic             wrap,
  output ch_state_t        state
);

  logic             button_q;
  logic             btn_ev;
  logic             adv;
  logic [WIDTH-1:0] entry_val;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;

  assign btn_ev = (BTN_EDGE != 0) ? (button & ~button_q) : button;
  assign adv    = ~hold & (auto_en ? tick : btn_ev);

  assign entry_val = (dir == DIR_DOWN) ? WIDTH'(MAX_VAL) : WIDTH'(MIN_VAL);
  assign step_val  = WIDTH'(next_colour(int'(colour), dir, MIN_VAL, MAX_VAL));
  assign step_wrap = is_wrap(int'(colour), dir, MIN_VAL, MAX_VAL);

  // button_q tracks the pin every cycle so a press made during hold or
  // auto mode cannot surface later as a stale edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      button_q <= 1'b0;
      state    <= IDLE;
      colour   <= '0;
      wrap     <= 1'b0;
    end else begin
      button_q <= button;
      wrap     <= 1'b0;
      if (adv) begin
        if (state == IDLE) begin
          state  <= RUN;
          colour <= entry_val;
        end else begin
          colour <= step_val;
          wrap   <= step_wrap;
        end
      end
    end
  end

endmodule

// File: rtl/led_colour_sequencer.sv
// Multi-channel LED colour sequencer: shared auto-advance tick generator feeding
// NUM_CH independent channels, each stepping through [MIN_VAL..MAX_VAL].
module led_colour_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int NUM_CH   = 2,
  parameter int MIN_VAL  = 1,
  parameter int MAX_VAL  = 6,
  parameter int BTN_EDGE = 0,
  parameter int PRESC_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       button,
  input  logic                    auto_en,
  input  logic                    dir,
  input  logic [NUM_CH-1:0]       hold,
  input  logic [PRESC_W-1:0]      auto_period,
  output logic [NUM_CH*WIDTH-1:0] colour,
  output logic [NUM_CH-1:0]       wrap
);

  logic [PRESC_W-1:0] cnt;
  logic               tick;

  // Combinational compare so a period of 0 ticks on every enabled cycle and
  // lowering the period below the running count fires straight away.
  assign tick = auto_en & (cnt >= auto_period);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!auto_en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  ch_state_t        ch_state  [NUM_CH];
  logic [WIDTH-1:0] ch_colour [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_seq_channel #(
      .WIDTH   (WIDTH),
      .MIN_VAL (MIN_VAL),
      .MAX_VAL (MAX_VAL),
      .BTN_EDGE(BTN_EDGE)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .button (button[i]),
      .tick   (tick),
      .auto_en(auto_en),
      .dir    (dir),
      .hold   (hold[i]),
      .colour (ch_colour[i]),
      .wrap   (wrap[i]),
      .state  (ch_state[i])
    );

    // An idle channel always drives 0 to the LED, whatever its register holds.
    assign colour[i*WIDTH +: WIDTH] = (ch_state[i] == RUN) ? ch_colour[i] : '0;
  end

endmodule
